mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Downstream neighbour of the EXE stage. Consumes ALU_result as a load/store address, or as a pass-through value.
- Performs a req/ack handshake with data memory and stalls EXE while a memory access is in flight.
- Delivers a one-cycle writeback bundle to the WB stage.
- Bounded wait: a bus timeout aborts a hung access.

Parameters:
- DATA_W, 32, datapath / address width (matches ALU_result)
- REG_ADDR_W, 5, destination register index width
- MAX_WAIT, 255, maximum cycles dmem_req may stay high without dmem_ack before abort

Ports:
- clk  in  1  single pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EXE presents a valid operation
- ex_ready  out  1  stage can accept; transfer when ex_valid&ex_ready
- ALU_result  in  DATA_W  address (mem op) or writeback value (non-mem op)
- store_data  in  DATA_W  B operand for stores
- mem_read  in  1  load
- mem_write  in  1  store
- reg_write  in  1  op writes a register
- rd  in  REG_ADDR_W  destination register
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  registered address
- dmem_wdata  out  DATA_W  registered store data
- dmem_ack  in  1  memory completion
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- wb_valid  out  1  one-cycle writeback pulse
- wb_reg_write  out  1  qualified register write enable
- wb_rd  out  REG_ADDR_W  destination register
- wb_data  out  DATA_W  load data or ALU_result
- bus_err  out  1  one-cycle pulse on timeout
- misalign_exc  out  1  one-cycle pulse on misaligned access

Behaviour:
- Reset (async, rst_n low): state=IDLE, wait counter=0.
  - dmem_req, dmem_we, wb_valid, wb_reg_write, bus_err, misalign_exc = 0.
  - dmem_addr, dmem_wdata, wb_rd, wb_data = 0.
  - ex_ready = 1 (combinational, state==IDLE).
- Reset mid-access: dmem_req drops immediately, the access is abandoned, and no wb_valid is produced.
- States:
  - IDLE: ex_ready=1.
  - BUSY: ex_ready=0, dmem_req=1.
- Accept at cycle N (IDLE & ex_valid), non-mem op:
  - wb_valid=1 at N+1 with wb_data=ALU_result, wb_reg_write=reg_write, wb_rd=rd.
  - Stays in IDLE, so back-to-back accepts are allowed.
- Accept at cycle N, mem op:
  - Latch addr, wdata, we, rd and reg_write.
  - dmem_req=1 from N+1; go BUSY.
- Read/write precedence: mem_read&mem_write both set is treated as a write. wb_data=ALU_result for that op.
- BUSY, ack at cycle M (dmem_ack sampled while dmem_req=1):
  - dmem_req=0 at M+1.
  - wb_valid=1 at M+1; wb_data=dmem_rdata captured at M for loads, ALU_result for stores.
  - Return to IDLE, so ex_ready=1 at M+1.
  - Minimum load latency: accept N -> wb N+2.
- Ack outside BUSY is ignored.
- Wait counter: clears on entry to BUSY and increments each BUSY cycle without ack.
- Timeout: counter==MAX_WAIT with no ack -> bus_err pulse, dmem_req=0, wb_valid=1 with wb_reg_write=0, return to IDLE.
  - Ack and timeout in the same cycle: ack wins, no bus_err.
- wb_valid, bus_err and misalign_exc are single-cycle pulses. wb_* data holds its value until the next pulse.

Optional Feature:
- MISALIGN_TRAP_EN defined: a mem op with ALU_result[1:0]!=0 issues no request. At N+1: misalign_exc=1, wb_valid=1, wb_reg_write=0; state stays IDLE.
- Not defined: dmem_addr[1:0] is forced to 00 (word-aligned access proceeds normally) and misalign_exc is tied 0.

Decomposition:
- Package mem_stage_pkg:
  - state enum {IDLE, BUSY}
  - DATA_W and REG_ADDR_W defaults
  - packed struct wb_bundle_t {reg_write, rd, data}
- One sub-module mem_wait_timer: clear/enable counter, width $clog2(MAX_WAIT+1), expired flag at MAX_WAIT.

Test Plan:
- Non-mem op, ALU_result=0x0000_0042, reg_write=1, rd=5 -> wb_valid at N+1, wb_data=0x42, wb_rd=5, dmem_req never asserted.
- Load addr 0x100, memory acks with rdata=0xDEAD_BEEF after 3 wait cycles -> dmem_req high 4 cycles, ex_ready low throughout, wb_data=0xDEADBEEF one cycle after ack.
- Store addr 0x204, store_data=0x1234_5678, zero-wait ack -> dmem_we=1, dmem_wdata=0x12345678, wb_valid with wb_reg_write=0.
- Load, no ack for MAX_WAIT=255 cycles -> bus_err pulse, wb_reg_write=0, ex_ready=1 next cycle. Repeat with ack on cycle 255 -> no bus_err.
- rst_n low while BUSY -> dmem_req=0 immediately, no wb_valid after release, next op accepted normally.
- Load addr 0x102: with MISALIGN_TRAP_EN -> misalign_exc at N+1, no dmem_req. Without it -> dmem_addr=0x100.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic                      reg_write;
        logic [DEF_REG_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0]     data;
    } wb_bundle_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// EXE-side, data-memory and writeback signals of the memory-access stage.
// The stage uses the master modport; the EXE/memory/WB side uses slave.
interface mem_access_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [DATA_W-1:0]     ALU_result;
    logic [DATA_W-1:0]     store_data;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [DATA_W-1:0]     dmem_addr;
    logic [DATA_W-1:0]     dmem_wdata;
    logic                  dmem_ack;
    logic [DATA_W-1:0]     dmem_rdata;

    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  bus_err;
    logic                  misalign_exc;

    modport master (
        input  ex_valid, ALU_result, store_data, mem_read, mem_write, reg_write, rd,
        input  dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_reg_write, wb_rd, wb_data, bus_err, misalign_exc
    );

    modport slave (
        output ex_valid, ALU_result, store_data, mem_read, mem_write, reg_write, rd,
        output dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_reg_write, wb_rd, wb_data, bus_err, misalign_exc
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles an access waits for its ack; saturates and flags expiry at MAX_WAIT.
module mem_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(MAX_WAIT));

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: req/ack data-memory handshake, bounded wait, WB pulse.
// Optional macro MISALIGN_TRAP_EN traps misaligned accesses instead of word-aligning them.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int MAX_WAIT   = 255
) (
    input logic                clk,
    input logic                rst_n,
    mem_access_stage_if.master bus
);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUSY = BUSY;

    logic [0:0]            state;
    logic                  pend_reg_write;
    logic [REG_ADDR_W-1:0] pend_rd;
    logic [DATA_W-1:0]     pend_alu;
    logic                  pend_load;

    logic accept;
    logic is_mem;
    logic trap;
    logic issue;
    logic busy;
    logic ack_hit;
    logic wait_cycle;
    logic expired;
    logic timeout;

    assign busy       = (state == ST_BUSY);
    assign accept     = !busy && bus.ex_valid;
    assign is_mem     = bus.mem_read | bus.mem_write;

`ifdef MISALIGN_TRAP_EN
    assign trap       = accept && is_mem && (bus.ALU_result[1:0] != 2'b00);
`else
    assign trap       = 1'b0;
`endif

    assign issue      = accept && is_mem && !trap;
    assign ack_hit    = busy && bus.dmem_ack;
    assign wait_cycle = busy && !bus.dmem_ack;
    assign timeout    = wait_cycle && expired;

    // dmem_req is a direct decode of the state flop, so reset removes it without a clock.
    assign bus.ex_ready = !busy;
    assign bus.dmem_req = busy;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (issue),
        .enable  (wait_cycle),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            pend_reg_write   <= 1'b0;
            pend_rd          <= '0;
            pend_alu         <= '0;
            pend_load        <= 1'b0;
            bus.dmem_we      <= 1'b0;
            bus.dmem_addr    <= '0;
            bus.dmem_wdata   <= '0;
            bus.wb_valid     <= 1'b0;
            bus.wb_reg_write <= 1'b0;
            bus.wb_rd        <= '0;
            bus.wb_data      <= '0;
            bus.bus_err      <= 1'b0;
            bus.misalign_exc <= 1'b0;
        end else begin
            bus.wb_valid     <= 1'b0;
            bus.bus_err      <= 1'b0;
            bus.misalign_exc <= 1'b0;

            // Non-memory ops and trapped accesses complete straight from IDLE.
            if (accept && !issue) begin
                bus.wb_valid     <= 1'b1;
                bus.wb_reg_write <= bus.reg_write && !trap;
                bus.wb_rd        <= bus.rd;
                bus.wb_data      <= bus.ALU_result;
                bus.misalign_exc <= trap;
            end

            // A simultaneous read+write is issued as a write.
            if (issue) begin
                state          <= ST_BUSY;
                bus.dmem_we    <= bus.mem_write;
                bus.dmem_addr  <= {bus.ALU_result[DATA_W-1:2], 2'b00};
                bus.dmem_wdata <= bus.store_data;
                pend_reg_write <= bus.reg_write;
                pend_rd        <= bus.rd;
                pend_alu       <= bus.ALU_result;
                pend_load      <= !bus.mem_write;
            end

            if (ack_hit) begin
                state            <= ST_IDLE;
                bus.wb_valid     <= 1'b1;
                bus.wb_reg_write <= pend_reg_write;
                bus.wb_rd        <= pend_rd;
                bus.wb_data      <= pend_load ? bus.dmem_rdata : pend_alu;
            end else if (timeout) begin
                state            <= ST_IDLE;
                bus.wb_valid     <= 1'b1;
                bus.wb_reg_write <= 1'b0;
                bus.wb_rd        <= pend_rd;
                bus.wb_data      <= pend_alu;
                bus.bus_err      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a writeback scoreboard checked on every WB pulse.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int MAX_WAIT = 255;

    typedef struct packed {
        wb_bundle_t wb;
        logic       bus_err;
        logic       misalign;
        logic       chk_payload;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    mem_access_stage #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t mon_exp;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_wb(input logic rw, input logic [4:0] rd, input logic [31:0] data,
                             input logic be, input logic mx, input logic chk);
        exp_t e;
        e.wb.reg_write = rw;
        e.wb.rd        = rd;
        e.wb.data      = data;
        e.bus_err      = be;
        e.misalign     = mx;
        e.chk_payload  = chk;
        sb.push_back(e);
    endtask

    task automatic drive_op(input logic [31:0] alu, input logic [31:0] sd, input logic mr,
                            input logic mw, input logic rw, input logic [4:0] rd);
        bus.ex_valid   = 1'b1;
        bus.ALU_result = alu;
        bus.store_data = sd;
        bus.mem_read   = mr;
        bus.mem_write  = mw;
        bus.reg_write  = rw;
        bus.rd         = rd;
    endtask

    task automatic idle_ex();
        bus.ex_valid  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.reg_write = 1'b0;
    endtask

    // Called on the negedge after an accept; returns on the first negedge with dmem_req low.
    task automatic mem_respond(input int waits, input logic [31:0] rdata, input bit give_ack,
                               output int req_cycles, output bit ready_seen);
        bit done = 1'b0;
        req_cycles = 0;
        ready_seen = 1'b0;
        for (int c = 0; c < 4 * MAX_WAIT && !done; c++) begin
            if (!bus.dmem_req) begin
                done = 1'b1;
            end else begin
                req_cycles++;
                ready_seen |= bus.ex_ready;
                if (give_ack && req_cycles == waits + 1) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = rdata;
                end else begin
                    bus.dmem_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.dmem_ack = 1'b0;
        if (!done) check("mem_wait_budget", 32'(bus.dmem_req), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.wb_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_wb", 32'(bus.wb_valid), 0);
                end else begin
                    mon_exp = sb.pop_front();
                    check("wb_reg_write", 32'(bus.wb_reg_write), 32'(mon_exp.wb.reg_write));
                    check("wb_bus_err", 32'(bus.bus_err), 32'(mon_exp.bus_err));
                    check("wb_misalign_exc", 32'(bus.misalign_exc), 32'(mon_exp.misalign));
                    if (mon_exp.chk_payload) begin
                        check("wb_rd", 32'(bus.wb_rd), 32'(mon_exp.wb.rd));
                        check("wb_data", bus.wb_data, mon_exp.wb.data);
                    end
                end
            end else begin
                check("stray_pulse", {30'b0, bus.bus_err, bus.misalign_exc}, 0);
            end
        end
    end

    initial begin
        int n;
        bit rs;
        rst_n          = 1'b0;
        bus.ALU_result = '0;
        bus.store_data = '0;
        bus.rd         = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        idle_ex();

        #3;
        check("rst_ex_ready", 32'(bus.ex_ready), 1);
        check("rst_dmem_req", 32'(bus.dmem_req), 0);
        check("rst_dmem_we", 32'(bus.dmem_we), 0);
        check("rst_dmem_addr", bus.dmem_addr, 0);
        check("rst_dmem_wdata", bus.dmem_wdata, 0);
        check("rst_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_wb_reg_write", 32'(bus.wb_reg_write), 0);
        check("rst_wb_rd", 32'(bus.wb_rd), 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_pulses", {30'b0, bus.bus_err, bus.misalign_exc}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back non-memory ops
        drive_op(32'h0000_0042, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5);
        expect_wb(1'b1, 5'd5, 32'h0000_0042, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("nonmem_wb_n1", 32'(bus.wb_valid), 1);
        check("nonmem_no_req", 32'(bus.dmem_req), 0);
        check("nonmem_ready", 32'(bus.ex_ready), 1);
        drive_op(32'h0000_0077, 32'h0, 1'b0, 1'b0, 1'b0, 5'd6);
        expect_wb(1'b0, 5'd6, 32'h0000_0077, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle_ex();
        check("b2b_wb", 32'(bus.wb_valid), 1);
        check("b2b_no_req", 32'(bus.dmem_req), 0);
        repeat (3) @(negedge clk);
        check("wb_data_hold", bus.wb_data, 32'h0000_0077);

        // Load with three wait cycles
        drive_op(32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);
        expect_wb(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle_ex();
        check("load_addr", bus.dmem_addr, 32'h0000_0100);
        check("load_we", 32'(bus.dmem_we), 0);
        mem_respond(3, 32'hDEAD_BEEF, 1'b1, n, rs);
        check("load_req_cycles", 32'(n), 4);
        check("load_ready_low", 32'(rs), 0);
        check("load_ready_after", 32'(bus.ex_ready), 1);

        // Zero-wait store, then read+write treated as store
        drive_op(32'h0000_0204, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd0);
        expect_wb(1'b0, 5'd0, 32'h0000_0204, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle_ex();
        check("store_we", 32'(bus.dmem_we), 1);
        check("store_wdata", bus.dmem_wdata, 32'h1234_5678);
        check("store_addr", bus.dmem_addr, 32'h0000_0204);
        mem_respond(0, 32'hBAD0_BAD0, 1'b1, n, rs);
        check("store_req_cycles", 32'(n), 1);
        drive_op(32'h0000_0208, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 5'd3);
        expect_wb(1'b1, 5'd3, 32'h0000_0208, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle_ex();
        check("rdwr_we", 32'(bus.dmem_we), 1);
        mem_respond(1, 32'hBAD1_BAD1, 1'b1, n, rs);
        check("rdwr_req_cycles", 32'(n), 2);

        // Ack while idle must be ignored
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        check("idle_ack_no_wb", 32'(bus.wb_valid), 0);
        check("idle_ack_ready", 32'(bus.ex_ready), 1);

        // Timeout with no ack
        drive_op(32'h0000_0300, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);
        expect_wb(1'b0, 5'd9, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        idle_ex();
        mem_respond(0, 32'h0, 1'b0, n, rs);
        check("timeout_req_cycles", 32'(n), MAX_WAIT + 1);
        check("timeout_bus_err", 32'(bus.bus_err), 1);
        check("timeout_ready", 32'(bus.ex_ready), 1);

        // Ack on the final allowed cycle beats the timeout
        drive_op(32'h0000_0304, 32'h0, 1'b1, 1'b0, 1'b1, 5'd10);
        expect_wb(1'b1, 5'd10, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle_ex();
        mem_respond(MAX_WAIT, 32'hCAFE_F00D, 1'b1, n, rs);
        check("late_ack_req_cycles", 32'(n), MAX_WAIT + 1);
        check("late_ack_no_err", 32'(bus.bus_err), 0);

        // Reset in the middle of an access
        drive_op(32'h0000_0400, 32'h0, 1'b1, 1'b0, 1'b1, 5'd11);
        @(negedge clk);
        idle_ex();
        @(negedge clk);
        check("busy_req_high", 32'(bus.dmem_req), 1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_drops_req", 32'(bus.dmem_req), 0);
        check("reset_ready", 32'(bus.ex_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_no_wb", 32'(bus.wb_valid), 0);
        drive_op(32'h0000_0099, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12);
        expect_wb(1'b1, 5'd12, 32'h0000_0099, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle_ex();
        check("post_reset_wb", 32'(bus.wb_valid), 1);

        // Misaligned load
        drive_op(32'h0000_0102, 32'h0, 1'b1, 1'b0, 1'b1, 5'd13);
`ifdef MISALIGN_TRAP_EN
        expect_wb(1'b0, 5'd13, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle_ex();
        check("misalign_exc", 32'(bus.misalign_exc), 1);
        check("misalign_no_req", 32'(bus.dmem_req), 0);
        check("misalign_ready", 32'(bus.ex_ready), 1);
`else
        expect_wb(1'b1, 5'd13, 32'h55AA_55AA, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        idle_ex();
        check("misalign_aligned_addr", bus.dmem_addr, 32'h0000_0100);
        mem_respond(1, 32'h55AA_55AA, 1'b1, n, rs);
        check("misalign_req_cycles", 32'(n), 2);
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
